// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow, synchronous flush and standard or FWFT read mode.
module sync_fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH),
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter bit FWFT       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH:0] DEPTH_C = DEPTH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AF_C    = AF_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AE_C    = AE_THRESH[PTR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH:0]    wr_ptr;
   logic [PTR_WIDTH:0]    rd_ptr;
   logic [PTR_WIDTH-1:0]  wr_idx;
   logic [PTR_WIDTH-1:0]  rd_idx;
   logic                  wr_ok;
   logic                  rd_ok;

   assign wr_idx = wr_ptr[PTR_WIDTH-1:0];
   assign rd_idx = rd_ptr[PTR_WIDTH-1:0];

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // Handshake: wr_en/rd_en are requests sampled at the rising edge; a request
   // is accepted in that same edge when wr_ok/rd_ok hold, otherwise it is
   // dropped and recorded in the sticky error flag. A read frees its slot in
   // the same edge, so a full FIFO accepts a simultaneous write.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   // Storage has no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_ok && !clr) begin
         mem[wr_idx] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (wr_en && !wr_ok) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_ok) begin
            underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out = empty ? '0 : mem[rd_idx];
      end else begin : g_std
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out <= '0;
            end else if (clr) begin
               data_out <= '0;
            end else if (rd_ok) begin
               data_out <= mem[rd_idx];
            end
         end
      end
   endgenerate

   // The wrap-bit pointer distance must always equal the registered count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count == wr_ptr - rd_ptr);
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: one standard-mode and one FWFT instance share the
// same randomized stimulus and are compared against a queue-based model.
module tb_sync_fifo_flex;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int PW    = $clog2(DEPTH);
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clr = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;

   logic [DW-1:0] dout_s, dout_f;
   logic          full_s, full_f, empty_s, empty_f;
   logic          af_s, af_f, ae_s, ae_f;
   logic [PW:0]   count_s, count_f;
   logic          ovf_s, ovf_f, unf_s, unf_f;

   // Reference model and scoreboard state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf, m_unf;
   bit            mon_en = 1'b0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            mon_n;

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut_std (
      .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
      .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
   );

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut_fwft (
      .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
      .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Driver: applies one cycle of stimulus and advances the model past the edge.
   task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
      int            n;
      bit            rd_ok, wr_ok;
      logic [DW-1:0] head;
      n     = mq.size();
      rd_ok = r && (n != 0);
      wr_ok = w && ((n != DEPTH) || rd_ok);
      head  = rd_ok ? mq[0] : '0;
      wr_en = w; rd_en = r; clr = c; data_in = d;
      if (!c && rd_ok) begin
         exp_q.push_back(head);
         exp_cyc_q.push_back(cyc + 1);
      end
      @(posedge clk);
      if (c) begin
         mq.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      end else begin
         if (rd_ok) begin
            void'(mq.pop_front());
            m_dout = head;
         end
         if (wr_ok) mq.push_back(d);
         if (w && !wr_ok) m_ovf = 1'b1;
         if (r && !rd_ok) m_unf = 1'b1;
      end
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
   endtask

   // Asynchronous reset: checked 1 ns after assertion, away from any clock edge.
   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("async_count", 32'({count_s, count_f}), 32'(0));
      check("async_empty", 32'({empty_s, empty_f}), 32'(2'b11));
      check("async_dout", 32'(dout_s), 32'(0));
      check("async_err", 32'({ovf_s, unf_s, ovf_f, unf_f}), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      mq.delete(); exp_q.delete(); exp_cyc_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   // Monitor / scoreboard: compares both instances on every falling edge.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         mon_n = mq.size();
         check("count_std", 32'(count_s), 32'(mon_n));
         check("count_fwft", 32'(count_f), 32'(mon_n));
         check("full", 32'({full_s, full_f}), 32'({2{mon_n == DEPTH}}));
         check("empty", 32'({empty_s, empty_f}), 32'({2{mon_n == 0}}));
         check("almost_full", 32'({af_s, af_f}), 32'({2{mon_n >= AF}}));
         check("almost_empty", 32'({ae_s, ae_f}), 32'({2{mon_n <= AE}}));
         check("overflow", 32'({ovf_s, ovf_f}), 32'({2{m_ovf}}));
         check("underflow", 32'({unf_s, unf_f}), 32'({2{m_unf}}));
         check("dout_hold", 32'(dout_s), 32'(m_dout));
         check("dout_fwft", 32'(dout_f), (mon_n == 0) ? 32'(0) : 32'(mq[0]));
         if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
            void'(exp_cyc_q.pop_front());
            check("rd_data", 32'(dout_s), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2;
      do_reset();

      // Fill to full, then one rejected write
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
      step(1'b1, 1'b0, 1'b0, 8'h09);

      // Drain in standard order, then one rejected read
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, '0);

      // Simultaneous read+write while full; 0xAA must come out last
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(16 + i));
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);

      // Simultaneous read+write while empty: write only, underflow set
      step(1'b1, 1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, '0);

      // Interleaved write/read pairs across several pointer wraps
      for (int i = 0; i < 40; i++) step(1'b1, i >= 4, 1'b0, 8'(i * 7 + 3));
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);

      // Randomized traffic with occasional flush
      repeat (400) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 39) == 0, 8'($urandom));
      end

      // Reset in the middle of traffic, then a fresh write/read
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(100 + i));
      #2;
      do_reset();
      step(1'b1, 1'b0, 1'b0, 8'hC3);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);

      // FWFT visibility, then flush with a concurrent write request
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b1, 8'h77);
      step(1'b0, 1'b0, 1'b0, '0);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_pending: got %0d outstanding expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
